result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each digit is driven before the scan advances (legal range 2..65535).
REQ-002 The module SHALL have port clock, input, 1 bit, system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port value, input, 16 bits, unsigned binary word to display (the processor result output).
REQ-005 The module SHALL have port busy, output, 1 bit, high while a binary-to-BCD conversion is in progress.
REQ-006 The module SHALL have port bcd, output, 20 bits, last completed conversion: five BCD digits, [3:0] ones through [19:16] ten-thousands.
REQ-007 The module SHALL have port seg, output, 7 bits, active-low segments, seg[0]=a through seg[6]=g.
REQ-008 The module SHALL have port an, output, 5 bits, active-low one-hot digit enable, an[0]=ones digit.

Function
REQ-009 Converter states SHALL be IDLE and SHIFT only; all outputs registered.
REQ-010 In IDLE, if value != lastValue (internal 16-bit snapshot), the block SHALL, on that edge, load value into the shift register, set lastValue<=value, clear the 20-bit scratch, clear the 4-bit iteration count, set busy=1, and enter SHIFT; otherwise remain in IDLE.
REQ-011 Each SHIFT cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit (double-dabble).
REQ-012 On the 16th SHIFT edge (count==15) the block SHALL write the shifted scratch to bcd, set busy=0, and return to IDLE.
REQ-013 Latency: change captured at edge k; bcd updated and busy cleared at edge k+16; busy high for exactly 16 cycles.
REQ-014 Changes of value during SHIFT SHALL be ignored by the running conversion; bcd SHALL be unchanged until completion.
REQ-015 If value differs from lastValue on returning to IDLE, a new conversion SHALL start on the next edge (no lost update, no retrigger when unchanged).
REQ-016 Scan prescaler SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance 0,1,2,3,4,0; scanning SHALL continue regardless of busy.
REQ-017 an SHALL be ~(1<<index); seg SHALL be registered decode of bcd digit[index], updated on the same edge as an.
REQ-018 Decode (seg[6:0], g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code SHALL give 1111111.
REQ-019 Leading-zero blanking: for index 1..4, seg SHALL be 1111111 when that digit and all higher digits are 0; index 0 SHALL always display.
REQ-020 Maximum value 65535 SHALL yield bcd 0x65535 with no overflow.

Reset
REQ-021 reset SHALL take priority over all other activity, including mid-conversion, aborting any conversion.
REQ-022 After reset: state IDLE, lastValue=0, bcd=0, busy=0, prescaler=0, index=0, an=11110, seg=1000000.
REQ-023 If value is nonzero while reset deasserts, a conversion SHALL start on the first edge after reset is low.

Verification
REQ-024 Reset, value=0 held 100 cycles -> busy never asserts, bcd=0x00000, ones digit shows 1000000, digits 1-4 blank.
REQ-025 value 0->1234 at edge k -> busy=1 after k through k+15, busy=0 and bcd=0x01234 after k+16; digit 4 blank, digit 3 shows 1111001.
REQ-026 value=65535 -> bcd=0x65535; SCAN_DIV=4: an sequence 11110,11101,11011,10111,01111,11110 each held 4 cycles.
REQ-027 value 100->200 at edge k+5 of a conversion -> bcd=0x00100 at k+16, then new conversion starts at k+17, bcd=0x00200 at k+33.
REQ-028 reset asserted at edge k+8 of a conversion of 999 -> busy=0, bcd=0; with value still 999, reconversion yields 0x00999.
REQ-029 Constant value 42 for 200 cycles after conversion -> exactly one busy pulse of 16 cycles.

Source files
------------

// File: rtl/result_display.sv
// result_display: double-dabble binary-to-BCD converter driving a scanned five-digit seven-segment display
module result_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  an
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state;
    logic [15:0] last_value;
    logic [15:0] shreg;
    logic [19:0] scratch;
    logic [19:0] adj;
    logic [3:0]  count;
    logic [15:0] prescale;
    logic        wrap;
    logic [2:0]  index;
    logic [2:0]  index_next;
    logic [3:0]  digit;
    logic [19:0] upper;
    logic        blank;
    logic [6:0]  seg_next;

    genvar i;
    for (i = 0; i < 5; i++) begin : g_adj
        assign adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end

    assign wrap       = prescale == 16'(SCAN_DIV - 1);
    assign index_next = wrap ? (index == 3'd4 ? 3'd0 : index + 3'd1) : index;
    assign digit      = bcd[{index_next, 2'b00} +: 4];
    assign upper      = bcd >> {index_next, 2'b00};
    assign blank      = index_next != 3'd0 && upper == 20'd0;

    // seven-segment decode of the digit about to be shown (g..a, active low)
    always_comb begin
        seg_next = 7'b1111111;
        case (digit)
            4'd0: seg_next = 7'b1000000;
            4'd1: seg_next = 7'b1111001;
            4'd2: seg_next = 7'b0100100;
            4'd3: seg_next = 7'b0110000;
            4'd4: seg_next = 7'b0011001;
            4'd5: seg_next = 7'b0010010;
            4'd6: seg_next = 7'b0000010;
            4'd7: seg_next = 7'b1111000;
            4'd8: seg_next = 7'b0000000;
            4'd9: seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
        endcase
    end

    // converter: snapshot a changed value, then 16 add-3-and-shift steps
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_value <= 16'd0;
            shreg      <= 16'd0;
            scratch    <= 20'd0;
            count      <= 4'd0;
            busy       <= 1'b0;
            bcd        <= 20'd0;
        end else if (state == IDLE) begin
            if (value != last_value) begin
                shreg      <= value;
                last_value <= value;
                scratch    <= 20'd0;
                count      <= 4'd0;
                busy       <= 1'b1;
                state      <= SHIFT;
            end
        end else begin
            {scratch, shreg} <= {adj, shreg} << 1;
            count            <= count + 4'd1;
            if (count == 4'd15) begin
                bcd   <= {adj[18:0], shreg[15]};
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    // digit scan: an and seg both follow the index they are about to show
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale <= 16'd0;
            index    <= 3'd0;
            an       <= 5'b11110;
            seg      <= 7'b1000000;
        end else begin
            prescale <= wrap ? 16'd0 : prescale + 16'd1;
            index    <= index_next;
            an       <= ~(5'b00001 << index_next);
            seg      <= blank ? 7'b1111111 : seg_next;
        end
    end
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed self-checking bench for result_display
module tb_result_display;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'd0;
    logic        busy;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [4:0]  an;
    int checks = 0;
    int passed = 0;

    result_display #(.SCAN_DIV(4)) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .busy(busy),
        .bcd(bcd),
        .seg(seg),
        .an(an)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_an(input logic [4:0] t);
        for (int n = 0; n < 40 && an !== t; n++) step();
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        int bad_seg = 0;
        logic [4:0] seen = 5'b0;
        reset = 1'b1;
        value = 16'd0;
        step();
        step();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h0) $display("FAIL reset_bcd: got %h expected 00000", bcd); else passed++;
        checks++; if (an !== 5'b11110) $display("FAIL reset_an: got %b expected 11110", an); else passed++;
        checks++; if (seg !== 7'b1000000) $display("FAIL reset_seg: got %b expected 1000000", seg); else passed++;
        reset = 1'b0;
        repeat (100) begin
            step();
            if (busy) busy_seen++;
            seen |= ~an;
            if (an == 5'b11110 ? seg !== 7'b1000000 : seg !== 7'b1111111) bad_seg++;
        end
        checks++; if (busy_seen !== 0) $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen); else passed++;
        checks++; if (bcd !== 20'h0) $display("FAIL zero_bcd: got %h expected 00000", bcd); else passed++;
        checks++; if (bad_seg !== 0) $display("FAIL zero_blanking: got %0d bad seg cycles expected 0", bad_seg); else passed++;
        checks++; if (seen !== 5'b11111) $display("FAIL zero_scan: got digits %b expected 11111", seen); else passed++;
    endtask

    task automatic test_convert();
        int hi = 0;
        value = 16'd1234;
        step();
        checks++; if (busy !== 1'b1) $display("FAIL conv_start: got busy %b expected 1", busy); else passed++;
        repeat (15) begin
            step();
            if (busy === 1'b1) hi++;
        end
        checks++; if (hi !== 15) $display("FAIL conv_busy_len: got %0d expected 15", hi); else passed++;
        checks++; if (bcd !== 20'h0) $display("FAIL conv_bcd_hold: got %h expected 00000", bcd); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL conv_done: got busy %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h01234) $display("FAIL conv_bcd: got %h expected 01234", bcd); else passed++;
        step();
        step();
        wait_an(5'b01111);
        checks++; if (an !== 5'b01111) $display("FAIL conv_wait_d4: got an %b expected 01111", an); else passed++;
        checks++; if (seg !== 7'b1111111) $display("FAIL conv_d4_blank: got %b expected 1111111", seg); else passed++;
        wait_an(5'b10111);
        checks++; if (seg !== 7'b1111001) $display("FAIL conv_d3: got %b expected 1111001", seg); else passed++;
        wait_an(5'b11110);
        checks++; if (seg !== 7'b0011001) $display("FAIL conv_d0: got %b expected 0011001", seg); else passed++;
    endtask

    task automatic test_max_scan();
        logic [4:0] an_seq [6] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
        logic [6:0] seg_seq [6] = '{7'b0010010, 7'b0110000, 7'b0010010, 7'b0010010, 7'b0000010, 7'b0010010};
        logic [4:0] prev;
        int n = 0;
        value = 16'd65535;
        repeat (17) step();
        checks++; if (busy !== 1'b0) $display("FAIL max_done: got busy %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h65535) $display("FAIL max_bcd: got %h expected 65535", bcd); else passed++;
        do begin
            prev = an;
            step();
            n++;
        end while (!(an == 5'b11110 && prev != 5'b11110) && n < 40);
        checks++; if (n >= 40) $display("FAIL scan_align: got timeout after %0d cycles expected 11110 entry", n); else passed++;
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < 4; c++) begin
                checks++; if (an !== an_seq[j]) $display("FAIL scan_an[%0d.%0d]: got %b expected %b", j, c, an, an_seq[j]); else passed++;
                checks++; if (seg !== seg_seq[j]) $display("FAIL scan_seg[%0d.%0d]: got %b expected %b", j, c, seg, seg_seq[j]); else passed++;
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        value = 16'd100;
        step();
        repeat (4) step();
        value = 16'd200;
        repeat (11) step();
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy15: got %b expected 1", busy); else passed++;
        checks++; if (bcd !== 20'h65535) $display("FAIL b2b_bcd_hold: got %h expected 65535", bcd); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL b2b_done1: got busy %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h00100) $display("FAIL b2b_bcd1: got %h expected 00100", bcd); else passed++;
        step();
        checks++; if (busy !== 1'b1) $display("FAIL b2b_restart: got busy %b expected 1", busy); else passed++;
        repeat (15) step();
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy32: got %b expected 1", busy); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL b2b_done2: got busy %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h00200) $display("FAIL b2b_bcd2: got %h expected 00200", bcd); else passed++;
    endtask

    task automatic test_reset_abort();
        value = 16'd999;
        step();
        repeat (7) step();
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busy); else passed++;
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h0) $display("FAIL abort_bcd: got %h expected 00000", bcd); else passed++;
        checks++; if (an !== 5'b11110) $display("FAIL abort_an: got %b expected 11110", an); else passed++;
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b1) $display("FAIL abort_restart: got busy %b expected 1", busy); else passed++;
        repeat (15) step();
        step();
        checks++; if (busy !== 1'b0) $display("FAIL abort_done: got busy %b expected 0", busy); else passed++;
        checks++; if (bcd !== 20'h00999) $display("FAIL abort_bcd2: got %h expected 00999", bcd); else passed++;
    endtask

    task automatic test_constant();
        int pulses = 0;
        int hi = 0;
        logic prev;
        value = 16'd42;
        repeat (220) begin
            prev = busy;
            step();
            if (busy && !prev) pulses++;
            if (busy) hi++;
        end
        checks++; if (pulses !== 1) $display("FAIL const_pulses: got %0d expected 1", pulses); else passed++;
        checks++; if (hi !== 16) $display("FAIL const_busy_len: got %0d expected 16", hi); else passed++;
        checks++; if (bcd !== 20'h00042) $display("FAIL const_bcd: got %h expected 00042", bcd); else passed++;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_max_scan();
        test_back_to_back();
        test_reset_abort();
        test_constant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
